ram_banked: RTL and testbench
=============================

Name: ram_banked

Overview:
- Parametrised banked synchronous RAM; next generation of the fixed-size cluster RAMs (ram16 → ram512).
- Storage is split into BANKS identical banks: upper address bits select the bank, lower bits select the row.
- Adds what the fixed blocks lack: a valid/ready request handshake, a registered read with a valid flag, and hardware zero-initialisation after reset or on a clear command.
- Drop-in memory for the CPU data path and any memory-mapped scratch storage.

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 512, total words; power of two.
- BANKS, 32, bank count; power of two, ≤ DEPTH.
- Derived (localparam): ADDR_W = clog2(DEPTH); ROW_W = clog2(DEPTH/BANKS); BANK_W = ADDR_W − ROW_W; ROWS = DEPTH/BANKS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  WIDTH  write data.
- addr  in  ADDR_W  word address; addr[ADDR_W-1:ROW_W] is the bank, addr[ROW_W-1:0] is the row.
- load  in  1  1 = write, 0 = read; qualified by req.
- req  in  1  request valid.
- clr  in  1  start zero-sweep of the whole array (single-cycle pulse).
- ready  out  1  accepting requests (high only in RUN).
- out  out  WIDTH  read data, registered.
- out_valid  out  1  one-cycle pulse when out holds fresh read data.
- init_done  out  1  high once the first sweep after reset has completed; stays high.

Behaviour:
- Reset (rst_n=0, async): state=INIT, row counter=0, out=0, out_valid=0, ready=0, init_done=0. Array contents are undefined until the sweep finishes.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, write 0 to row cnt in all banks in parallel; cnt++.
  - When cnt==ROWS−1 the write happens, cnt←0, state→RUN, init_done←1.
  - Sweep takes exactly ROWS cycles; ready=0 throughout.
  - req is ignored (not queued); clr is ignored.
- RUN:
  - ready=1.
  - Accept when req&&ready at the edge.
  - Write (load=1): mem[bank][row]←in at that edge; out is unchanged; out_valid=0 next cycle.
  - Read (load=0): out←mem[bank][row] at that edge; out_valid=1 in the following cycle only.
  - Read latency is 1 cycle.
  - Back-to-back requests are allowed every cycle.
  - Read of an address written in the previous cycle returns the new data.
- clr in RUN:
  - Takes priority over a coincident req; the request is dropped and nothing is written.
  - Next cycle state=INIT and ready=0; out_valid=0; init_done stays 1; out holds its last value.
- Only the selected bank's write enable asserts; all other banks hold.
- The read mux is driven by the bank index registered alongside the read.
- Reset asserted mid-sweep or mid-access: everything returns to the reset values and the sweep restarts from row 0 after release.
- Address is always in range by construction; no wrap logic beyond the counter wrapping at ROWS−1.
- BANKS==DEPTH (ROWS=1): the sweep is 1 cycle, ROW_W=0, and the row index is tied to 0.

Decomposition:
- Package ram_pkg:
  - clog2 constant function.
  - state enum (INIT, RUN) as a 1-bit typedef.
  - Parameter-legality checks used by elaboration assertions: DEPTH and BANKS powers of two, BANKS ≤ DEPTH.
- Sub-module ram_bank:
  - Parameters: WIDTH, ROWS. Ports: clk, we, row, din, dout.
  - Synchronous write, synchronous read, no reset on storage.
  - ram_banked instantiates BANKS copies via generate, plus the FSM, sweep counter, bank decode and output mux/register.

Test Plan:
- Reset-init: defaults; release rst_n → ready stays 0 for exactly 16 cycles, then ready=1 and init_done=1. Reading addr 0, 255 and 511 gives out=0x0000 with out_valid high for one cycle.
- Write/read: write 0xBEEF @ addr 0x1A3 (bank 26, row 3), then read 0x1A3 the next cycle → out=0xBEEF one cycle after the read. Reads of 0x1A2 and 0x0A3 return 0x0000, proving bank/row isolation.
- Back-to-back: write 0x1234 @ 5, read 5, read 6 on consecutive cycles → out_valid high two consecutive cycles with out=0x1234 then 0x0000. out_valid is low in the cycle after the write.
- Full sweep: write addr^0x5A5A to all 512 addresses, read all back → every word matches; no out_valid during the writes.
- clr mid-run: after writing 0xFFFF @ 100, pulse clr together with req (write 0x1111 @ 7) → the write is dropped and ready=0 for 16 cycles. Afterwards addr 100 and addr 7 both read 0x0000; init_done stays 1 throughout.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 8 → out=0 and ready=0 immediately. After release the sweep again takes a full 16 cycles before ready=1.
- Param variant WIDTH=8, DEPTH=64, BANKS=64 → 1-cycle sweep; write 0xA5 @ 63, read 63 → 0xA5.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the banked RAM.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(
    input int w,
    input int d,
    input int b
  );
    return (w >= 1) && is_pow2(d) &&
           is_pow2(b) && (b <= d);
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One bank of storage: synchronous write and read, no reset.
module ram_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS  = 16,
  localparam int RW = (ROWS > 1) ? clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [RW-1:0]    row,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [ROWS];

  if (ROWS > 1) begin : g_multi
    always_ff @(posedge clk) begin
      if (we) mem_q[row] <= din;
      dout <= mem_q[row];
    end
  end else begin : g_single
    logic unused_row;
    assign unused_row = ^row;
    always_ff @(posedge clk) begin
      if (we) mem_q[0] <= din;
      dout <= mem_q[0];
    end
  end

endmodule

// File: rtl/ram_banked.sv
// Banked synchronous RAM with valid/ready requests,
// registered read and hardware zero sweep.
module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int BANKS = 32,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int ROW_W  = clog2(DEPTH / BANKS),
  localparam int BANK_W = ADDR_W - ROW_W,
  localparam int ROWS   = DEPTH / BANKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              req,
  input  logic              clr,
  output logic              ready,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              init_done
);

  localparam int RW = (ROW_W > 0) ? ROW_W : 1;
  localparam int BW = (BANK_W > 0) ? BANK_W : 1;

  if (!params_ok(WIDTH, DEPTH, BANKS)) begin : g_bad
    $error("ram_banked: illegal WIDTH/DEPTH/BANKS");
  end

  logic [RW-1:0] a_row;
  logic [BW-1:0] a_bank;

  if (ROW_W > 0) begin : g_row
    assign a_row = addr[ROW_W-1:0];
  end else begin : g_norow
    assign a_row = '0;
  end

  if (BANK_W > 0) begin : g_bank
    assign a_bank = addr[ADDR_W-1:ROW_W];
  end else begin : g_nobank
    assign a_bank = '0;
  end

  state_e           state_q, state_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             rd_q, rd_d;
  logic [BW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic [BANKS-1:0] we;
  logic [RW-1:0]    row_sel;
  logic [WIDTH-1:0] din_sel;
  logic [WIDTH-1:0] dout [BANKS];
  logic [WIDTH-1:0] rdata;

  for (genvar b = 0; b < BANKS; b++) begin : g_banks
    ram_bank #(
      .WIDTH(WIDTH),
      .ROWS (ROWS)
    ) u_bank (
      .clk (clk),
      .we  (we[b]),
      .row (row_sel),
      .din (din_sel),
      .dout(dout[b])
    );
  end

  if (BANKS > 1) begin : g_mux
    assign rdata = dout[sel_q];
  end else begin : g_nomux
    assign rdata = dout[0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    rd_d    = 1'b0;
    sel_d   = sel_q;
    we      = '0;
    row_sel = a_row;
    din_sel = in;
    hold_d  = rd_q ? rdata : hold_q;
    case (state_q)
      INIT: begin
        we      = '1;
        row_sel = cnt_q;
        din_sel = '0;
        if (cnt_q == RW'(ROWS - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // clr wins over a coincident request
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (req) begin
          if (load) begin
            we[a_bank] = 1'b1;
          end else begin
            rd_d  = 1'b1;
            sel_d = a_bank;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      sel_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign ready     = (state_q == RUN);
  assign out       = rd_q ? rdata : hold_q;
  assign out_valid = rd_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_ram_banked.sv
// Directed self-checking bench for ram_banked
// (default geometry plus a one-row-per-bank variant).
module tb_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in;
  logic [8:0]  addr;
  logic        load, req, clr;
  logic        ready, out_valid, init_done;
  logic [15:0] out;

  logic [7:0]  p_in;
  logic [5:0]  p_addr;
  logic        p_load, p_req, p_clr;
  logic        p_ready, p_out_valid, p_init_done;
  logic [7:0]  p_out;

  int n_tests = 0;
  int n_fail  = 0;

  ram_banked dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .addr(addr), .load(load), .req(req),
    .clr(clr), .ready(ready), .out(out),
    .out_valid(out_valid),
    .init_done(init_done)
  );

  ram_banked #(
    .WIDTH(8), .DEPTH(64), .BANKS(64)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .in(p_in),
    .addr(p_addr), .load(p_load),
    .req(p_req), .clr(p_clr),
    .ready(p_ready), .out(p_out),
    .out_valid(p_out_valid),
    .init_done(p_init_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(
    input int    start,
    input int    exp,
    input string nm,
    output int   done_lo
  );
    int n;
    n = start;
    done_lo = 0;
    while (!ready && n < 40) begin
      if (init_done !== 1'b1) done_lo++;
      tick;
      n++;
    end
    n_tests++;
    if (n != exp || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: cycles=%0d ready=%b, need %0d/1",
               nm, n, ready, exp);
    end
  endtask

  task automatic do_write(
    input logic [8:0]  a,
    input logic [15:0] d
  );
    addr = a; in = d; load = 1'b1; req = 1'b1;
    tick;
    req = 1'b0; load = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_valid @%h: out_valid=%b, need 0",
               a, out_valid);
    end
  endtask

  task automatic do_read(
    input logic [8:0]  a,
    input logic [15:0] exp
  );
    addr = a; load = 1'b0; req = 1'b1;
    tick;
    req = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out !== exp) begin
      n_fail++;
      $display("FAIL rd @%h: out=%h v=%b, need %h v=1",
               a, out, out_valid, exp);
    end
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_pulse @%h: out_valid=%b, need 0",
               a, out_valid);
    end
  endtask

  task automatic test_reset;
    int lo;
    rst_n = 1'b0;
    in = '0; addr = '0; load = 0; req = 0; clr = 0;
    p_in = '0; p_addr = '0;
    p_load = 0; p_req = 0; p_clr = 0;
    tick;
    tick;
    n_tests++;
    if (ready !== 0 || out !== 16'h0 ||
        out_valid !== 0 || init_done !== 0) begin
      n_fail++;
      $display("FAIL rst_vals: r=%b o=%h v=%b d=%b, need 0",
               ready, out, out_valid, init_done);
    end
    rst_n = 1'b1;
    tick;
    n_tests++;
    if (p_ready !== 1 || p_init_done !== 1) begin
      n_fail++;
      $display("FAIL p_sweep: r=%b d=%b, need 1/1",
               p_ready, p_init_done);
    end
    wait_ready(1, 16, "init_sweep", lo);
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: %b, need 1", init_done);
    end
    do_read(9'd0,   16'h0000);
    do_read(9'd255, 16'h0000);
    do_read(9'd511, 16'h0000);
  endtask

  task automatic test_write_read;
    do_write(9'h1A3, 16'hBEEF);
    do_read(9'h1A3, 16'hBEEF);
    do_read(9'h1A2, 16'h0000);
    do_read(9'h0A3, 16'h0000);
  endtask

  task automatic test_back_to_back;
    addr = 9'd5; in = 16'h1234;
    load = 1'b1; req = 1'b1;
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_wr: v=%b, need 0", out_valid);
    end
    load = 1'b0;
    tick;
    n_tests++;
    if (out_valid !== 1 || out !== 16'h1234) begin
      n_fail++;
      $display("FAIL b2b_rd5: o=%h v=%b, need 1234 v=1",
               out, out_valid);
    end
    addr = 9'd6;
    tick;
    req = 1'b0;
    n_tests++;
    if (out_valid !== 1 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL b2b_rd6: o=%h v=%b, need 0000 v=1",
               out, out_valid);
    end
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: v=%b, need 0", out_valid);
    end
  endtask

  task automatic test_clr;
    int lo;
    do_write(9'd100, 16'hFFFF);
    addr = 9'd7; in = 16'h1111;
    load = 1'b1; req = 1'b1; clr = 1'b1;
    tick;
    clr = 1'b0; req = 1'b0; load = 1'b0;
    n_tests++;
    if (ready !== 0 || out_valid !== 0 ||
        init_done !== 1) begin
      n_fail++;
      $display("FAIL clr_enter: r=%b v=%b d=%b, need 0/0/1",
               ready, out_valid, init_done);
    end
    wait_ready(0, 16, "clr_sweep", lo);
    n_tests++;
    if (lo != 0) begin
      n_fail++;
      $display("FAIL clr_done: low cycles=%0d, need 0", lo);
    end
    do_read(9'd100, 16'h0000);
    do_read(9'd7,   16'h0000);
  endtask

  task automatic test_full_sweep;
    logic [15:0] exp;
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a); in = 16'(a) ^ 16'h5A5A;
      load = 1'b1; req = 1'b1;
      tick;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fs_wr %0d: v=%b, need 0",
                 a, out_valid);
      end
    end
    load = 1'b0;
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a);
      exp = 16'(a) ^ 16'h5A5A;
      tick;
      n_tests++;
      if (out_valid !== 1 || out !== exp) begin
        n_fail++;
        $display("FAIL fs_rd %0d: o=%h v=%b, need %h v=1",
                 a, out, out_valid, exp);
      end
    end
    req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_sweep;
    int lo;
    do_read(9'd1, 16'h5A5B);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (7) tick;
    n_tests++;
    if (ready !== 0 || out !== 16'h5A5B) begin
      n_fail++;
      $display("FAIL mid_hold: r=%b o=%h, need 0 5a5b",
               ready, out);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out !== 16'h0 || ready !== 0 ||
        out_valid !== 0 || init_done !== 0) begin
      n_fail++;
      $display("FAIL mid_rst: o=%h r=%b v=%b d=%b, need 0",
               out, ready, out_valid, init_done);
    end
    tick;
    rst_n = 1'b1;
    wait_ready(0, 16, "resweep", lo);
    do_read(9'd1, 16'h0000);
  endtask

  task automatic test_param_variant;
    n_tests++;
    if (p_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL p_ready: %b, need 1", p_ready);
    end
    p_addr = 6'd63; p_in = 8'hA5;
    p_load = 1'b1; p_req = 1'b1;
    tick;
    p_load = 1'b0;
    n_tests++;
    if (p_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL p_wr: v=%b, need 0", p_out_valid);
    end
    tick;
    p_addr = 6'd62;
    n_tests++;
    if (p_out_valid !== 1 || p_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL p_rd63: o=%h v=%b, need a5 v=1",
               p_out, p_out_valid);
    end
    tick;
    p_req = 1'b0;
    n_tests++;
    if (p_out_valid !== 1 || p_out !== 8'h00) begin
      n_fail++;
      $display("FAIL p_rd62: o=%h v=%b, need 00 v=1",
               p_out, p_out_valid);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_clr;
    test_full_sweep;
    test_reset_mid_sweep;
    test_param_variant;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
